ascii_frame_loader: RTL and testbench



---
 rtl/digscan_pkg.sv | 19 +
 rtl/wd_timer.sv | 25 ++
 rtl/ascii_frame_loader.sv | 142 ++++++++++++++
 tb/tb_ascii_frame_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digscan_pkg.sv
// Shared constants and state encoding for the digit-scan datapath.
// The scanner relies on the same DEPTH/ADDR_W as the loader.
package digscan_pkg;

   localparam int unsigned DEPTH     = 16;
   localparam int unsigned ADDR_W    = 4;
   localparam logic [7:0]  TERM_CHAR = 8'h0A;
   localparam logic [7:0]  PAD_CHAR  = 8'h20;
   localparam int unsigned TIMEOUT   = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PAD,
      ST_FIRE,
      ST_WAIT_DONE
   } state_t;

endpackage

// File: rtl/wd_timer.sv
// Watchdog counter: synchronous clear, count enable, terminal count at LIMIT-1.
module wd_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_count <= '0;
      else if (i_en)
         r_count <= r_count + 1'b1;
   end

   assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/ascii_frame_loader.sv
// Loads one DEPTH-entry ASCII frame into the register file, pads short lines,
// then hands off to the digit scanner via go/done and clears it with scan_rst.
module ascii_frame_loader #(
   parameter int unsigned DEPTH     = digscan_pkg::DEPTH,
   parameter int unsigned ADDR_W    = digscan_pkg::ADDR_W,
   parameter logic [7:0]  TERM_CHAR = digscan_pkg::TERM_CHAR,
   parameter logic [7:0]  PAD_CHAR  = digscan_pkg::PAD_CHAR,
   parameter int unsigned TIMEOUT   = digscan_pkg::TIMEOUT
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] W_Addr,
   output logic              W_en,
   output logic [7:0]        W_Data,
   output logic              go,
   input  logic              done,
   output logic              scan_rst,
   output logic [4:0]        frame_len,
   output logic              busy,
   output logic              err
);

   import digscan_pkg::*;

   localparam int unsigned      TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_ptr,   w_ptr_nxt;
   logic [4:0]        r_len,   w_len_nxt;
   logic              r_err,   w_err_nxt;
   logic              w_term;
   logic              w_last;
   logic              w_tmr_clr;
   logic              w_tmr_tc;

   assign w_term = (in_data == TERM_CHAR);
   assign w_last = (r_ptr[ADDR_W-1:0] == LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_len_nxt   = r_len;
      w_err_nxt   = r_err;
      w_tmr_clr   = 1'b0;
      in_ready    = 1'b0;
      W_en        = 1'b0;
      W_Data      = in_data;
      go          = 1'b0;
      scan_rst    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !w_term) begin
               W_en        = 1'b1;
               w_ptr_nxt   = (ADDR_W+1)'(1);
               w_len_nxt   = 5'd1;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_LOAD;
            end
         end

         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!w_term) begin
                  W_en      = 1'b1;
                  w_ptr_nxt = r_ptr + 1'b1;
                  w_len_nxt = r_len + 1'b1;
                  if (w_last)
                     w_state_nxt = ST_FIRE;
               end else begin
                  w_state_nxt = ST_PAD;
               end
            end
         end

         ST_PAD: begin
            W_en      = 1'b1;
            W_Data    = PAD_CHAR;
            w_ptr_nxt = r_ptr + 1'b1;
            if (w_last)
               w_state_nxt = ST_FIRE;
         end

         ST_FIRE: begin
            go          = 1'b1;
            w_ptr_nxt   = '0;
            w_tmr_clr   = 1'b1;
            w_state_nxt = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            // done is checked first so a coincident timeout does not flag err
            if (done) begin
               scan_rst    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_tmr_tc) begin
               scan_rst    = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_len   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_len   <= w_len_nxt;
         r_err   <= w_err_nxt;
      end
   end

   wd_timer #(
      .WIDTH (TMR_W),
      .LIMIT (TIMEOUT)
   ) u_wd_timer (
      .i_clk (Clk),
      .i_clr (Rst || w_tmr_clr),
      .i_en  (r_state == ST_WAIT_DONE),
      .o_tc  (w_tmr_tc)
   );

   assign W_Addr    = r_ptr[ADDR_W-1:0];
   assign frame_len = r_len;
   assign err       = r_err;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ascii_frame_loader.sv
// Scoreboard bench for ascii_frame_loader with a simple scanner model.
module tb_ascii_frame_loader;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] W_Addr;
   logic       W_en;
   logic [7:0] W_Data;
   logic       go;
   logic       done = 1'b0;
   logic       scan_rst;
   logic [4:0] frame_len;
   logic       busy;
   logic       err;

   localparam logic [7:0] TERM = 8'h0A;
   localparam logic [7:0] PAD  = 8'h20;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  exp_ptr  = 0;
   bit  done_en  = 1'b1;
   int  done_delay = 40;

   ascii_frame_loader dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .W_Addr    (W_Addr),
      .W_en      (W_en),
      .W_Data    (W_Data),
      .go        (go),
      .done      (done),
      .scan_rst  (scan_rst),
      .frame_len (frame_len),
      .busy      (busy),
      .err       (err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every register-file write must match the head of the queue
   always @(negedge Clk) begin
      if (W_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", W_Addr, W_Data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (W_Addr !== e.a || W_Data !== e.d) begin
               n_fail++;
               $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                        W_Addr, W_Data, e.a, e.d);
            end
         end
      end
   end

   // Scanner model: raises done done_delay cycles after go, drops it after scan_rst
   initial begin
      forever begin
         @(negedge Clk);
         if (go === 1'b1 && done_en) begin
            repeat (done_delay) @(posedge Clk);
            #1 done = 1'b1;
            for (int g = 0; g < 400; g++) begin
               @(negedge Clk);
               if (scan_rst === 1'b1) break;
            end
            @(posedge Clk);
            #1 done = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int g;
      g = 0;
      while (in_ready !== 1'b1 && g < 1000) begin
         @(posedge Clk); #1;
         g++;
      end
      if (in_ready !== 1'b1) begin
         chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
         return;
      end
      if (b != TERM) begin
         exp_q.push_back('{4'(exp_ptr), b});
         exp_ptr++;
      end
      in_data  = b;
      in_valid = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      if (b == TERM && exp_ptr > 0) begin
         for (int a = exp_ptr; a < 16; a++) exp_q.push_back('{4'(a), PAD});
         exp_ptr = 0;
      end else if (exp_ptr == 16) begin
         exp_ptr = 0;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // go must stay low for lat-1 cycles and be high on the lat-th
   task automatic expect_go(input int lat, input int len);
      bit ok;
      ok = 1'b1;
      for (int i = 1; i <= lat; i++) begin
         @(negedge Clk);
         if (i < lat && go !== 1'b0) ok = 1'b0;
      end
      chk("go_early_low", {31'd0, ok}, 32'd1);
      chk("go_pulse", {31'd0, go}, 32'd1);
      chk("frame_len_at_go", {27'd0, frame_len}, 32'(len));
   endtask

   task automatic finish_frame(input int lat, input logic e_err);
      int i;
      for (i = 1; i <= 400; i++) begin
         @(negedge Clk);
         if (scan_rst === 1'b1) break;
      end
      chk("scan_rst_latency", 32'(i), 32'(lat));
      @(negedge Clk);
      chk("scan_rst_single", {31'd0, scan_rst}, 32'd0);
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("err_after", {31'd0, err}, {31'd0, e_err});
      @(posedge Clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_w_en", {31'd0, W_en}, 32'd0);
      chk("rst_go", {31'd0, go}, 32'd0);
      chk("rst_scan_rst", {31'd0, scan_rst}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_frame_len", {27'd0, frame_len}, 32'd0);

      // Full frame, back-to-back, done after 40 cycles
      send_str("A1b2c3d4e5f6g7h8");
      expect_go(1, 16);
      finish_frame(40, 1'b0);
      chk("frame_len_held", {27'd0, frame_len}, 32'd16);

      // Short line "12" + TERM: 14 pad cycles
      send_str("12");
      send(TERM);
      expect_go(15, 2);
      finish_frame(40, 1'b0);

      // Empty line in IDLE is dropped
      send(TERM);
      @(negedge Clk);
      chk("empty_busy", {31'd0, busy}, 32'd0);
      chk("empty_go", {31'd0, go}, 32'd0);
      @(posedge Clk); #1;
      send("7");
      send(TERM);
      expect_go(16, 1);
      finish_frame(40, 1'b0);

      // Timeout: scanner never answers
      done_en = 1'b0;
      send("X");
      send(TERM);
      expect_go(16, 1);
      finish_frame(255, 1'b1);
      chk("err_sticky", {31'd0, err}, 32'd1);
      done_en = 1'b1;
      send("Q");
      chk("err_cleared", {31'd0, err}, 32'd0);
      send(TERM);
      expect_go(16, 1);
      finish_frame(40, 1'b0);

      // done coinciding with the timeout cycle: done wins
      done_delay = 255;
      send("5");
      send(TERM);
      expect_go(16, 1);
      finish_frame(255, 1'b0);
      done_delay = 40;

      // Reset in PAD at ptr 9
      send_str("12345");
      send(TERM);
      repeat (4) @(posedge Clk);
      #1 Rst = 1'b1;
      @(posedge Clk);
      #1 Rst = 1'b0;
      exp_q.delete();
      exp_ptr = 0;
      chk("padrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("padrst_w_en", {31'd0, W_en}, 32'd0);
      chk("padrst_go", {31'd0, go}, 32'd0);
      chk("padrst_busy", {31'd0, busy}, 32'd0);
      chk("padrst_frame_len", {27'd0, frame_len}, 32'd0);
      send("9");
      send(TERM);
      expect_go(16, 1);
      finish_frame(40, 1'b0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
